write_back_stage: RTL and testbench

Final pipeline stage: takes completed results from the memory stage, selects ALU or load data, and drives the register-file write port and flag write with a one-cycle registered delay. It also owns the register scoreboard that operand fetch consults. Operand fetch asks whether its source registers still have writes in flight, and write-back answers with a stall. It is the write end of the register file, whose read end is operand fetch.

---
 rtl/wb_pkg.sv | 28 ++
 rtl/wb_scoreboard.sv | 49 ++++
 rtl/write_back_stage.sv | 65 ++++++
 tb/tb_write_back_stage.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared widths, operand-fetch bundle offsets and the write-back result record.
package wb_pkg;
  localparam int DATA_W       = 64;
  localparam int REG_ADDR_W   = 4;
  localparam int NUM_REGS     = 16;
  localparam int MAX_INFLIGHT = 3;
  localparam int CNT_W        = 2;
  localparam int OF_CTRL_LSB  = 0;
  localparam int OF_CTRL_MSB  = 7;
  localparam int OF_PC_LSB    = 8;
  localparam int OF_PC_MSB    = 15;
  localparam int OF_REG1_LSB  = 16;
  localparam int OF_REG1_MSB  = 79;
  localparam int OF_REG2_LSB  = 80;
  localparam int OF_REG2_MSB  = 143;
  localparam int OF_FLAG_BIT  = 144;
  localparam int OF_ADDR_LSB  = 145;
  localparam int OF_ADDR_MSB  = 152;
  localparam int OF_DEST_LSB  = 153;
  localparam int OF_DEST_MSB  = 156;
  typedef struct packed {
    logic                  en;
    logic                  flag_en;
    logic                  flag;
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wb_result_t;
endpackage

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: per-register in-flight write counters, issue stall and sticky error flag.
module wb_scoreboard
  import wb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  input  logic                  issue_writes,
  input  logic [REG_ADDR_W-1:0] issue_dest,
  input  logic [REG_ADDR_W-1:0] issue_src1,
  input  logic [REG_ADDR_W-1:0] issue_src2,
  input  logic                  issue_use1,
  input  logic                  issue_use2,
  input  logic                  commit_en,
  input  logic [REG_ADDR_W-1:0] commit_addr,
  output logic                  stall,
  output logic                  sb_error
);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_INFLIGHT);
  logic [CNT_W-1:0]    cnt_q [NUM_REGS];
  logic [CNT_W-1:0]    cnt_d [NUM_REGS];
  logic [NUM_REGS-1:0] inc_v, dec_v;
  logic                inc, unf, ovf, err_q, err_d;
  assign stall = issue_valid & ((issue_use1 & cnt_q[issue_src1] != '0) |
                                (issue_use2 & cnt_q[issue_src2] != '0) |
                                (issue_writes & cnt_q[issue_dest] == CNT_MAX));
  assign inc   = issue_valid & ~stall & issue_writes;
  assign inc_v = inc ? NUM_REGS'(1) << issue_dest : '0;
  assign dec_v = commit_en ? NUM_REGS'(1) << commit_addr : '0;
  assign unf   = commit_en & cnt_q[commit_addr] == '0;
  // a matching commit in the same cycle cancels the increment, so no overflow then
  assign ovf   = inc & cnt_q[issue_dest] == CNT_MAX & ~(commit_en & commit_addr == issue_dest);
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++)
      cnt_d[r] = (inc_v[r] & ~dec_v[r] & cnt_q[r] != CNT_MAX) ? cnt_q[r] + 1'b1 :
                 (dec_v[r] & ~inc_v[r] & cnt_q[r] != '0)      ? cnt_q[r] - 1'b1 : cnt_q[r];
    err_d = err_q | unf | ovf;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign sb_error = err_q;
endmodule

// File: rtl/write_back_stage.sv
// write_back_stage: result mux and registered register-file/flag write port with retire counter.
module write_back_stage
  import wb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  input  logic                  issue_writes,
  input  logic [REG_ADDR_W-1:0] issue_dest,
  input  logic [REG_ADDR_W-1:0] issue_src1,
  input  logic [REG_ADDR_W-1:0] issue_src2,
  input  logic                  issue_use1,
  input  logic                  issue_use2,
  output logic                  stall,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_dest,
  input  logic [DATA_W-1:0]     wb_alu_data,
  input  logic [DATA_W-1:0]     wb_mem_data,
  input  logic                  wb_mem_to_reg,
  input  logic                  wb_flag_write,
  input  logic                  wb_flag,
  output logic                  rf_write_en,
  output logic [REG_ADDR_W-1:0] rf_write_addr,
  output logic [DATA_W-1:0]     rf_write_data,
  output logic                  rf_flag_write_en,
  output logic                  rf_flag,
  output logic [15:0]           retired_count,
  output logic                  sb_error
);
  wb_result_t  res_q, res_d;
  logic [15:0] ret_q, ret_d;
  always_comb begin
    res_d.en      = wb_valid;
    res_d.flag_en = wb_valid & wb_flag_write;
    res_d.flag    = wb_valid ? wb_flag : res_q.flag;
    res_d.addr    = wb_valid ? wb_dest : res_q.addr;
    res_d.data    = wb_valid ? (wb_mem_to_reg ? wb_mem_data : wb_alu_data) : res_q.data;
    ret_d         = ret_q + 16'(res_q.en);
  end
  always_ff @(posedge clk) begin
    res_q <= rst ? '0 : res_d;
    ret_q <= rst ? '0 : ret_d;
  end
  assign rf_write_en      = res_q.en;
  assign rf_write_addr    = res_q.addr;
  assign rf_write_data    = res_q.data;
  assign rf_flag_write_en = res_q.flag_en;
  assign rf_flag          = res_q.flag;
  assign retired_count    = ret_q;
  wb_scoreboard u_sb (
    .clk          (clk),
    .rst          (rst),
    .issue_valid  (issue_valid),
    .issue_writes (issue_writes),
    .issue_dest   (issue_dest),
    .issue_src1   (issue_src1),
    .issue_src2   (issue_src2),
    .issue_use1   (issue_use1),
    .issue_use2   (issue_use2),
    .commit_en    (res_q.en),
    .commit_addr  (res_q.addr),
    .stall        (stall),
    .sb_error     (sb_error)
  );
endmodule

// File: tb/tb_write_back_stage.sv
// tb_write_back_stage: directed steps with a commit scoreboard queue and a retire-count model.
module tb_write_back_stage;
  logic        clk = 1'b0;
  logic        rst, issue_valid, issue_writes, issue_use1, issue_use2, stall;
  logic [3:0]  issue_dest, issue_src1, issue_src2, wb_dest, rf_write_addr;
  logic        wb_valid, wb_mem_to_reg, wb_flag_write, wb_flag;
  logic [63:0] wb_alu_data, wb_mem_data, rf_write_data;
  logic        rf_write_en, rf_flag_write_en, rf_flag, sb_error;
  logic [15:0] retired_count;
  typedef struct {
    logic [3:0]  addr;
    logic [63:0] data;
    logic        fe;
    logic        f;
  } exp_t;
  exp_t        q[$];
  logic [15:0] exp_ret = '0;
  logic        committing = 1'b0;
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;

  write_back_stage dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_writes(issue_writes),
    .issue_dest(issue_dest), .issue_src1(issue_src1), .issue_src2(issue_src2),
    .issue_use1(issue_use1), .issue_use2(issue_use2), .stall(stall),
    .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_alu_data(wb_alu_data),
    .wb_mem_data(wb_mem_data), .wb_mem_to_reg(wb_mem_to_reg),
    .wb_flag_write(wb_flag_write), .wb_flag(wb_flag), .rf_write_en(rf_write_en),
    .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data),
    .rf_flag_write_en(rf_flag_write_en), .rf_flag(rf_flag),
    .retired_count(retired_count), .sb_error(sb_error)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    exp_t e;
    if (rst) begin
      q.delete();
      committing = 1'b0;
      exp_ret = '0;
    end else begin
      if (committing) exp_ret++;
      committing = wb_valid;
      if (wb_valid)
        q.push_back('{wb_dest, wb_mem_to_reg ? wb_mem_data : wb_alu_data, wb_flag_write, wb_flag});
    end
    @(posedge clk);
    #1;
    chk("wr_en", 64'(rf_write_en), 64'(q.size() != 0));
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("wr_addr", 64'(rf_write_addr), 64'(e.addr));
      chk("wr_data", rf_write_data, e.data);
      chk("flag_en", 64'(rf_flag_write_en), 64'(e.fe));
      chk("flag", 64'(rf_flag), 64'(e.f));
    end
    chk("retired", 64'(retired_count), 64'(exp_ret));
  endtask

  task automatic issue(input logic v, input logic w, input logic [3:0] d,
                       input logic [3:0] s1, input logic u1);
    issue_valid = v; issue_writes = w; issue_dest = d;
    issue_src1 = s1; issue_use1 = u1; issue_src2 = 4'd0; issue_use2 = 1'b0;
  endtask

  task automatic wb(input logic v, input logic [3:0] d, input logic [63:0] alu,
                    input logic [63:0] mem, input logic m2r, input logic fw, input logic f);
    wb_valid = v; wb_dest = d; wb_alu_data = alu; wb_mem_data = mem;
    wb_mem_to_reg = m2r; wb_flag_write = fw; wb_flag = f;
  endtask

  initial begin
    // reset with a live write-back request that must be dropped
    rst = 1'b1;
    issue(1'b1, 1'b0, 4'd0, 4'd0, 1'b1);
    wb(1'b1, 4'd3, 64'hAAAA, 64'hBBBB, 1'b0, 1'b1, 1'b1);
    tick();
    rst = 1'b0;
    wb(1'b0, 4'd0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
    chk("rst_addr", 64'(rf_write_addr), 64'd0);
    chk("rst_data", rf_write_data, 64'd0);
    chk("rst_flag_en", 64'(rf_flag_write_en), 64'd0);
    chk("rst_flag", 64'(rf_flag), 64'd0);
    chk("rst_sb_error", 64'(sb_error), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    // RAW hazard on r5
    issue(1'b1, 1'b1, 4'd5, 4'd0, 1'b0);
    #1 chk("raw_issue_stall", 64'(stall), 64'd0);
    tick();
    issue(1'b1, 1'b0, 4'd0, 4'd5, 1'b1);
    wb(1'b1, 4'd5, 64'hDEAD, 64'h0, 1'b0, 1'b0, 1'b0);
    #1 chk("raw_stall", 64'(stall), 64'd1);
    tick();
    wb(1'b0, 4'd0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
    #1 chk("raw_stall_commit", 64'(stall), 64'd1);
    tick();
    chk("raw_release", 64'(stall), 64'd0);
    chk("raw_retired", 64'(retired_count), 64'd1);
    // mem select with flag update, issued alongside so r1 never underflows
    issue(1'b1, 1'b1, 4'd1, 4'd0, 1'b0);
    wb(1'b1, 4'd1, 64'hFFFF, 64'h1234, 1'b1, 1'b1, 1'b1);
    tick();
    issue(1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    wb(1'b0, 4'd0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
    chk("mux_data", rf_write_data, 64'h1234);
    tick();
    chk("mux_hold_data", rf_write_data, 64'h1234);
    chk("mux_sb_error", 64'(sb_error), 64'd0);
    // saturation on r2
    for (int i = 0; i < 3; i++) begin
      issue(1'b1, 1'b1, 4'd2, 4'd0, 1'b0);
      #1 chk("sat_issue", 64'(stall), 64'd0);
      tick();
    end
    #1 chk("sat_stall_dest", 64'(stall), 64'd1);
    tick();
    issue(1'b1, 1'b0, 4'd0, 4'd2, 1'b1);
    #1 chk("sat_stall_src", 64'(stall), 64'd1);
    chk("sat_sb_error", 64'(sb_error), 64'd0);
    // same-cycle increment and decrement on r7
    issue(1'b1, 1'b1, 4'd7, 4'd0, 1'b0);
    tick();
    issue(1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    wb(1'b1, 4'd7, 64'h77, 64'h0, 1'b0, 1'b0, 1'b0);
    tick();
    issue(1'b1, 1'b1, 4'd7, 4'd0, 1'b0);
    wb(1'b0, 4'd0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
    #1 chk("same_issue_stall", 64'(stall), 64'd0);
    tick();
    issue(1'b1, 1'b0, 4'd0, 4'd7, 1'b1);
    #1 chk("same_src_stall", 64'(stall), 64'd1);
    issue(1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    wb(1'b1, 4'd7, 64'h78, 64'h0, 1'b0, 1'b0, 1'b0);
    tick();
    wb(1'b0, 4'd0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
    tick();
    issue(1'b1, 1'b0, 4'd0, 4'd7, 1'b1);
    #1 chk("same_cleared", 64'(stall), 64'd0);
    chk("same_sb_error", 64'(sb_error), 64'd0);
    issue(1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    // underflow on r9
    wb(1'b1, 4'd9, 64'h99, 64'h0, 1'b0, 1'b0, 1'b0);
    tick();
    wb(1'b0, 4'd0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
    chk("unf_before", 64'(sb_error), 64'd0);
    tick();
    chk("unf_set", 64'(sb_error), 64'd1);
    tick();
    chk("unf_sticky", 64'(sb_error), 64'd1);
    // retire counter wrap via back-to-back commits
    while (exp_ret != 16'hFFFF) begin
      wb(1'b1, 4'd9, 64'(exp_ret), 64'h0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    wb(1'b0, 4'd0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("wrap_zero", 64'(retired_count), 64'd0);
    chk("wrap_sticky", 64'(sb_error), 64'd1);
    // reset mid-flight drops the pending result and counts
    issue(1'b1, 1'b1, 4'd4, 4'd0, 1'b0);
    tick();
    issue(1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    wb(1'b1, 4'd4, 64'h4444, 64'h0, 1'b0, 1'b1, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wb(1'b0, 4'd0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
    chk("mid_rst_data", rf_write_data, 64'd0);
    chk("mid_rst_sb_error", 64'(sb_error), 64'd0);
    issue(1'b1, 1'b0, 4'd0, 4'd4, 1'b1);
    #1 chk("mid_rst_stall", 64'(stall), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
